trace_checker: RTL and testbench



---
 rtl/trace_checker_pkg.sv | 30 +++
 rtl/trace_capture.sv | 36 +++
 rtl/trace_checker.sv | 170 +++++++++++++++++
 tb/tb_trace_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_checker_pkg.sv
// Shared types and constants for the write-back trace checker.
package trace_checker_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned FC_W  = 3;

    // Checker FSM states; PASS and FAIL are terminal until reset.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    // Failure codes reported on fail_code.
    localparam logic [FC_W-1:0] FC_NONE     = 3'd0;
    localparam logic [FC_W-1:0] FC_PC       = 3'd1;
    localparam logic [FC_W-1:0] FC_REG      = 3'd2;
    localparam logic [FC_W-1:0] FC_VALUE    = 3'd3;
    localparam logic [FC_W-1:0] FC_TIMEOUT  = 3'd4;
    localparam logic [FC_W-1:0] FC_OVERFLOW = 3'd5;

    // One captured architectural register write.
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  value;
    } wb_t;

endpackage

// File: rtl/trace_capture.sv
// Filtered capture register for the CPU write-back debug stream.
// Only retiring instructions that write a non-zero register raise cap_vld.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   have_inst, ena      retire present, register-file write enable
//   rd, pc, value       destination register, retire PC, write data
//   cap_vld             registered "architectural write captured"
//   cap                 registered write payload
module trace_capture
    import trace_checker_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             have_inst,
    input  logic             ena,
    input  logic [REG_W-1:0] rd,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  value,
    output logic             cap_vld,
    output wb_t              cap
);

    // Writes to x0 are architecturally invisible and are never checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld <= 1'b0;
            cap     <= '0;
        end else begin
            cap_vld  <= have_inst & ena & (rd != '0);
            cap.pc    <= pc;
            cap.rd    <= rd;
            cap.value <= value;
        end
    end

endmodule

// File: rtl/trace_checker.sv
// In-order checker of CPU register writes against a golden trace memory.
// Declares PASS at the golden end-marker, FAIL on the first mismatching
// field, on pointer overflow, or (optionally) on an idle timeout.
// Optional feature macro: TRACE_CHECKER_TIMEOUT_EN builds the idle counter
// and enables fail code 4.
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   debug_wb_have_inst/pc/ena/reg/value CPU retirement stream
//   gold_addr                           golden entry pointer
//   gold_pc/reg/value/end               golden entry at gold_addr (comb read)
//   done, pass                          terminal / passing status
//   fail_code, fail_pc, fail_expect, fail_actual  first-failure record
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int unsigned TRACE_AW       = 14,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                debug_wb_have_inst,
    input  logic [XLEN-1:0]     debug_wb_pc,
    input  logic                debug_wb_ena,
    input  logic [REG_W-1:0]    debug_wb_reg,
    input  logic [XLEN-1:0]     debug_wb_value,
    output logic [TRACE_AW-1:0] gold_addr,
    input  logic [XLEN-1:0]     gold_pc,
    input  logic [REG_W-1:0]    gold_reg,
    input  logic [XLEN-1:0]     gold_value,
    input  logic                gold_end,
    output logic                done,
    output logic                pass,
    output logic [FC_W-1:0]     fail_code,
    output logic [XLEN-1:0]     fail_pc,
    output logic [XLEN-1:0]     fail_expect,
    output logic [XLEN-1:0]     fail_actual
);

    localparam logic [TRACE_AW-1:0] ADDR_MAX = {TRACE_AW{1'b1}};

    logic cap_vld;
    wb_t  cap;

    state_e              state, state_nxt;
    logic [TRACE_AW-1:0] addr_nxt;
    logic [FC_W-1:0]     code_nxt;
    logic [XLEN-1:0]     fpc_nxt, fexp_nxt, fact_nxt;

    trace_capture u_capture (
        .clk       (clk),
        .rst_n     (rst_n),
        .have_inst (debug_wb_have_inst),
        .ena       (debug_wb_ena),
        .rd        (debug_wb_reg),
        .pc        (debug_wb_pc),
        .value     (debug_wb_value),
        .cap_vld   (cap_vld),
        .cap       (cap)
    );

`ifdef TRACE_CHECKER_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);

    logic [IDLE_W-1:0] idle_cnt, idle_nxt;

    // Saturating count of RUN cycles without an accepted capture.
    always_comb begin
        idle_nxt = idle_cnt;
        if (state == ST_RUN) begin
            if (cap_vld) begin
                idle_nxt = '0;
            end else if (idle_cnt != IDLE_LIMIT) begin
                idle_nxt = idle_cnt + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_nxt;
        end
    end
`else
    // TIMEOUT_CYCLES is kept on the interface but has no effect here.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_unused
    end
`endif

    // Next-state, pointer and failure-record logic.
    always_comb begin
        state_nxt = state;
        addr_nxt  = gold_addr;
        code_nxt  = fail_code;
        fpc_nxt   = fail_pc;
        fexp_nxt  = fail_expect;
        fact_nxt  = fail_actual;
        case (state)
            ST_RUN: begin
                if (gold_end) begin
                    // End-marker wins over a same-cycle capture.
                    state_nxt = ST_PASS;
                end else if (cap_vld) begin
                    fpc_nxt = cap.pc;
                    if (cap.pc != gold_pc) begin
                        state_nxt = ST_FAIL;
                        code_nxt  = FC_PC;
                        fexp_nxt  = gold_pc;
                        fact_nxt  = cap.pc;
                    end else if (cap.rd != gold_reg) begin
                        state_nxt = ST_FAIL;
                        code_nxt  = FC_REG;
                        fexp_nxt  = XLEN'(gold_reg);
                        fact_nxt  = XLEN'(cap.rd);
                    end else if (cap.value != gold_value) begin
                        state_nxt = ST_FAIL;
                        code_nxt  = FC_VALUE;
                        fexp_nxt  = gold_value;
                        fact_nxt  = cap.value;
                    end else if (gold_addr == ADDR_MAX) begin
                        // Last entry matched with no end-marker: never wrap.
                        state_nxt = ST_FAIL;
                        code_nxt  = FC_OVERFLOW;
                        fexp_nxt  = gold_value;
                        fact_nxt  = cap.value;
                    end else begin
                        fpc_nxt  = fail_pc;
                        addr_nxt = gold_addr + TRACE_AW'(1);
                    end
                end
`ifdef TRACE_CHECKER_TIMEOUT_EN
                else if (idle_cnt == IDLE_LIMIT) begin
                    state_nxt = ST_FAIL;
                    code_nxt  = FC_TIMEOUT;
                    fpc_nxt   = '0;
                    fexp_nxt  = gold_pc;
                    fact_nxt  = '0;
                end
`endif
            end
            default: ;
        endcase
    end

    // State, pointer and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            gold_addr   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
            fail_pc     <= '0;
            fail_expect <= '0;
            fail_actual <= '0;
        end else begin
            state       <= state_nxt;
            gold_addr   <= addr_nxt;
            done        <= (state_nxt != ST_RUN);
            pass        <= (state_nxt == ST_PASS);
            fail_code   <= code_nxt;
            fail_pc     <= fpc_nxt;
            fail_expect <= fexp_nxt;
            fail_actual <= fact_nxt;
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Directed self-checking bench for trace_checker (TRACE_AW=2, TIMEOUT_CYCLES=16).
module tb_trace_checker;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_have, wb_ena;
    logic [31:0]   wb_pc, wb_value;
    logic [4:0]    wb_reg;
    logic [AW-1:0] gold_addr;
    logic [31:0]   gold_pc, gold_value;
    logic [4:0]    gold_reg;
    logic          gold_end;
    logic          done, pass;
    logic [2:0]    fail_code;
    logic [31:0]   fail_pc, fail_expect, fail_actual;

    logic [31:0] g_pc  [4];
    logic [4:0]  g_reg [4];
    logic [31:0] g_val [4];
    logic        g_end [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign gold_pc    = g_pc[gold_addr];
    assign gold_reg   = g_reg[gold_addr];
    assign gold_value = g_val[gold_addr];
    assign gold_end   = g_end[gold_addr];

    trace_checker #(.TRACE_AW(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .debug_wb_have_inst (wb_have),
        .debug_wb_pc        (wb_pc),
        .debug_wb_ena       (wb_ena),
        .debug_wb_reg       (wb_reg),
        .debug_wb_value     (wb_value),
        .gold_addr          (gold_addr),
        .gold_pc            (gold_pc),
        .gold_reg           (gold_reg),
        .gold_value         (gold_value),
        .gold_end           (gold_end),
        .done               (done),
        .pass               (pass),
        .fail_code          (fail_code),
        .fail_pc            (fail_pc),
        .fail_expect        (fail_expect),
        .fail_actual        (fail_actual)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_gold();
        for (int i = 0; i < 4; i++) begin
            g_pc[i] = '0; g_reg[i] = '0; g_val[i] = '0; g_end[i] = 1'b0;
        end
    endtask

    task automatic set_gold(input int i, input logic [31:0] pc, input logic [4:0] rd,
                            input logic [31:0] v, input logic e);
        g_pc[i] = pc; g_reg[i] = rd; g_val[i] = v; g_end[i] = e;
    endtask

    // Present one retirement for one cycle; returns 1 time unit after the capturing edge.
    task automatic put(input logic have, input logic en, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] v);
        wb_have = have; wb_ena = en; wb_reg = rd; wb_pc = pc; wb_value = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) put(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    endtask

    // Assert reset (possibly mid-run), check cleared outputs, release at a falling edge.
    task automatic do_reset();
        wb_have = 1'b0; wb_ena = 1'b0; wb_reg = '0; wb_pc = '0; wb_value = '0;
        rst_n = 1'b0;
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_code", 32'(fail_code), 32'd0);
        check("rst_addr", 32'(gold_addr), 32'd0);
        check("rst_fpc", fail_pc, 32'd0);
        check("rst_fexp", fail_expect, 32'd0);
        check("rst_fact", fail_actual, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load_two();
        clear_gold();
        set_gold(0, 32'h0, 5'd1, 32'd5, 1'b0);
        set_gold(1, 32'h4, 5'd2, 32'd7, 1'b0);
        set_gold(2, 32'h0, 5'd0, 32'd0, 1'b1);
    endtask

    task automatic load_four();
        clear_gold();
        for (int i = 0; i < 4; i++)
            set_gold(i, 32'(4 * i), 5'(i + 1), 32'h11 * 32'(i + 1), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_have = 1'b0; wb_ena = 1'b0; wb_reg = '0; wb_pc = '0; wb_value = '0;
        load_two();

        // Clean run, back-to-back writes.
        do_reset();
        put(1'b1, 1'b1, 5'd1, 32'h0, 32'd5);
        put(1'b1, 1'b1, 5'd2, 32'h4, 32'd7);
        idle(1);
        check("clean_addr2", 32'(gold_addr), 32'd2);
        check("clean_not_yet", 32'(pass), 32'd0);
        idle(1);
        check("clean_pass", 32'(pass), 32'd1);
        check("clean_done", 32'(done), 32'd1);
        check("clean_code", 32'(fail_code), 32'd0);
        put(1'b1, 1'b1, 5'd9, 32'h40, 32'd1);
        idle(2);
        check("clean_held_pass", 32'(pass), 32'd1);
        check("clean_held_code", 32'(fail_code), 32'd0);

        // Value mismatch on the second write.
        do_reset();
        put(1'b1, 1'b1, 5'd1, 32'h0, 32'd5);
        put(1'b1, 1'b1, 5'd2, 32'h4, 32'd8);
        idle(1);
        check("val_code", 32'(fail_code), 32'd3);
        check("val_done", 32'(done), 32'd1);
        check("val_pass", 32'(pass), 32'd0);
        check("val_fpc", fail_pc, 32'h4);
        check("val_fexp", fail_expect, 32'd7);
        check("val_fact", fail_actual, 32'd8);
        put(1'b1, 1'b1, 5'd2, 32'h4, 32'd7);
        idle(2);
        check("val_held_code", 32'(fail_code), 32'd3);
        check("val_held_fact", fail_actual, 32'd8);
        check("val_held_pass", 32'(pass), 32'd0);

        // PC and REG both wrong: PC has priority.
        do_reset();
        put(1'b1, 1'b1, 5'd3, 32'h10, 32'd9);
        idle(1);
        check("pc_code", 32'(fail_code), 32'd1);
        check("pc_fexp", fail_expect, 32'h0);
        check("pc_fact", fail_actual, 32'h10);
        check("pc_fpc", fail_pc, 32'h10);

        // REG mismatch with correct PC.
        do_reset();
        put(1'b1, 1'b1, 5'd3, 32'h0, 32'd5);
        idle(1);
        check("reg_code", 32'(fail_code), 32'd2);
        check("reg_fexp", fail_expect, 32'd1);
        check("reg_fact", fail_actual, 32'd3);
        check("reg_fpc", fail_pc, 32'h0);

        // Filtering of x0 writes, ena=0 and have_inst=0 cycles.
        do_reset();
        put(1'b1, 1'b1, 5'd1, 32'h0, 32'd5);
        put(1'b1, 1'b1, 5'd0, 32'h8, 32'd9);
        put(1'b1, 1'b0, 5'd3, 32'h8, 32'd1);
        check("filt_addr_a", 32'(gold_addr), 32'd1);
        put(1'b0, 1'b1, 5'd3, 32'h8, 32'd1);
        check("filt_addr_b", 32'(gold_addr), 32'd1);
        check("filt_running", 32'(done), 32'd0);
        put(1'b1, 1'b1, 5'd2, 32'h4, 32'd7);
        idle(1);
        check("filt_addr2", 32'(gold_addr), 32'd2);
        idle(1);
        check("filt_pass", 32'(pass), 32'd1);
        check("filt_code", 32'(fail_code), 32'd0);

        // Idle timeout after one matching write.
        do_reset();
        put(1'b1, 1'b1, 5'd1, 32'h0, 32'd5);
        idle(17);
`ifdef TRACE_CHECKER_TIMEOUT_EN
        check("to_not_early", 32'(done), 32'd0);
        idle(1);
        check("to_code", 32'(fail_code), 32'd4);
        check("to_fexp", fail_expect, 32'h4);
        check("to_fpc", fail_pc, 32'h0);
        check("to_fact", fail_actual, 32'h0);
        check("to_addr", 32'(gold_addr), 32'd1);
`else
        idle(20);
        check("to_still_run", 32'(done), 32'd0);
        check("to_no_code", 32'(fail_code), 32'd0);
        check("to_addr", 32'(gold_addr), 32'd1);
`endif

        // Reset mid-run after three entries, then an empty trace.
        load_four();
        do_reset();
        put(1'b1, 1'b1, 5'd1, 32'h0, 32'h11);
        put(1'b1, 1'b1, 5'd2, 32'h4, 32'h22);
        put(1'b1, 1'b1, 5'd3, 32'h8, 32'h33);
        idle(1);
        check("mid_addr3", 32'(gold_addr), 32'd3);
        check("mid_running", 32'(done), 32'd0);
        set_gold(0, 32'h0, 5'd0, 32'd0, 1'b1);
        do_reset();
        check("empty_pass", 32'(pass), 32'd1);
        check("empty_done", 32'(done), 32'd1);
        check("empty_addr", 32'(gold_addr), 32'd0);

        // Overflow at the last address.
        load_four();
        do_reset();
        put(1'b1, 1'b1, 5'd1, 32'h0, 32'h11);
        put(1'b1, 1'b1, 5'd2, 32'h4, 32'h22);
        put(1'b1, 1'b1, 5'd3, 32'h8, 32'h33);
        put(1'b1, 1'b1, 5'd4, 32'hc, 32'h44);
        check("ovf_addr_pre", 32'(gold_addr), 32'd3);
        check("ovf_running", 32'(done), 32'd0);
        idle(1);
        check("ovf_code", 32'(fail_code), 32'd5);
        check("ovf_done", 32'(done), 32'd1);
        check("ovf_pass", 32'(pass), 32'd0);
        check("ovf_fpc", fail_pc, 32'hc);
        idle(2);
        check("ovf_addr_hold", 32'(gold_addr), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
